// File: rtl/mix_columns_engine_pkg.sv
// Shared types and GF(2^8) arithmetic for the MixColumns engine.
// Multiplication is an xtime shift-and-add chain; no tables.
package mix_columns_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [7:0] POLY = 8'h1B;

  localparam logic [0:3][7:0] FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] INV_ROW = {8'h0E, 8'h0B, 8'h0D, 8'h09};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational transform of one 32-bit column (forward or inverse MixColumns).
// Byte 0 of the column sits in bits [31:24].
module mix_column_unit
  import mix_columns_engine_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [0:3][7:0] a_bytes;
  logic [0:3][7:0] b_bytes;

  assign a_bytes = col_in;
  assign col_out = b_bytes;

  // Output byte i takes coefficient row rotated right by i: index (j - i) mod 4.
  always_comb begin
    logic [1:0] k;
    logic [7:0] coef;
    b_bytes = '0;
    k       = 2'd0;
    coef    = 8'h00;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        k    = 2'(j - i);
        coef = inv ? INV_ROW[k] : FWD_ROW[k];
        b_bytes[2'(i)] = b_bytes[2'(i)] ^ gmul(a_bytes[2'(j)], coef);
      end
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative MixColumns / InvMixColumns engine: latch a state, transform
// COLS_PER_CYCLE columns per cycle, then hold the result until taken.
module mix_columns_engine
  import mix_columns_engine_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int PIPE_OUT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [0:3][31:0]  work_q, work_d;
  logic              mode_q, mode_d;
  logic [127:0]      dout_q, dout_d;
  logic              out_valid_q, out_valid_d;

  logic [1:0]  unit_idx [COLS_PER_CYCLE];
  logic [31:0] unit_in  [COLS_PER_CYCLE];
  logic [31:0] unit_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
    assign unit_idx[k] = col_q + 2'(k);
    assign unit_in[k]  = work_q[unit_idx[k]];
    mix_column_unit u_col (
      .col_in  (unit_in[k]),
      .inv     (mode_q),
      .col_out (unit_out[k])
    );
  end

  // Next-state logic; with PIPE_OUT the result is copied into dout one cycle into HOLD.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    mode_d      = mode_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          mode_d  = inv;
          col_d   = 2'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[unit_idx[k]] = unit_out[k];
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          state_d = HOLD;
        end else begin
          state_d = CALC;
        end
      end
      HOLD: begin
        if (PIPE_OUT != 0) begin
          if (!out_valid_q) begin
            dout_d      = work_q;
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset beats any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (PIPE_OUT != 0) ? out_valid_q : (state_q == HOLD);
  assign data_out  = (PIPE_OUT != 0) ? dout_q : work_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench driving four engine configurations in parallel:
// (1,1) (2,1) (4,1) (1,0) as (COLS_PER_CYCLE, PIPE_OUT).
module tb_mix_columns_engine;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic [127:0] data_in;
  logic         out_ready;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   busy;
  logic [127:0] dout [4];

  int checks;
  int errors;

  logic [127:0] res [4];
  int           lat [4];
  int           exp_lat [4];

  localparam logic [127:0] S_F1   = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] EXP_F1 = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] S_F2   = 128'h2d26314c_01010101_c6c6c6c6_db135345;
  localparam logic [127:0] EXP_F2 = 128'h4d7ebdf8_01010101_c6c6c6c6_8e4da1bc;
  localparam logic [127:0] OTHER  = 128'h00112233_44556677_8899aabb_ccddeeff;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    mix_columns_engine #(
      .COLS_PER_CYCLE ((gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 1),
      .PIPE_OUT       ((gi == 3) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[gi]),
      .inv       (inv),
      .data_in   (data_in),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready),
      .data_out  (dout[gi]),
      .busy      (busy[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One operation on all instances with out_ready=1; records result and latency.
  task automatic run_op(input logic [127:0] din, input logic mode, input bit toggle);
    @(negedge clk);
    data_in   = din;
    inv       = mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0;
      res[i] = '0;
    end
    for (int c = 1; c <= 8; c++) begin
      if (toggle) inv = ~inv;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (lat[i] == 0 && out_valid[i]) begin
          lat[i] = c;
          res[i] = dout[i];
        end else if (lat[i] != 0 && c == lat[i] + 1) begin
          checks++;
          if (in_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_handshake inst%0d: in_ready=%b expected 1", i, in_ready[i]);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lat[i] == 0) begin
        errors++;
        $display("FAIL timeout inst%0d: out_valid never rose, expected within 8 cycles", i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || busy[i] !== 1'b0 || out_valid[i] !== 1'b0 || dout[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset inst%0d: in_ready=%b busy=%b out_valid=%b data_out=%h expected 1 0 0 0",
                 i, in_ready[i], busy[i], out_valid[i], dout[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    run_op(S_F1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== EXP_F1) begin
        errors++;
        $display("FAIL fwd1 inst%0d: got %h expected %h", i, res[i], EXP_F1);
      end
      checks++;
      if (lat[i] !== exp_lat[i]) begin
        errors++;
        $display("FAIL latency inst%0d: got %0d expected %0d", i, lat[i], exp_lat[i]);
      end
    end
    run_op(S_F2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== EXP_F2) begin
        errors++;
        $display("FAIL fwd2 inst%0d: got %h expected %h", i, res[i], EXP_F2);
      end
    end
  endtask

  task automatic test_inverse();
    run_op(EXP_F1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== S_F1) begin
        errors++;
        $display("FAIL inv1 inst%0d: got %h expected %h", i, res[i], S_F1);
      end
      checks++;
      if (lat[i] !== exp_lat[i]) begin
        errors++;
        $display("FAIL inv_latency inst%0d: got %0d expected %0d", i, lat[i], exp_lat[i]);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [127:0] s;
    logic [127:0] mid;
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(s, 1'b0, 1'b0);
      mid = res[0];
      run_op(mid, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res[i] !== s) begin
          errors++;
          $display("FAIL inv_of_fwd inst%0d vec%0d: got %h expected %h", i, n, res[i], s);
        end
      end
      run_op(s, 1'b1, 1'b0);
      mid = res[0];
      run_op(mid, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (res[i] !== s) begin
          errors++;
          $display("FAIL fwd_of_inv inst%0d vec%0d: got %h expected %h", i, n, res[i], s);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    data_in   = S_F1;
    inv       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'hF) begin
      errors++;
      $display("FAIL bp_valid: out_valid=%b expected 1111", out_valid);
    end
    for (int t = 0; t < 10; t++) begin
      in_valid = 1'b1;
      data_in  = OTHER;
      inv      = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 || dout[i] !== EXP_F1) begin
          errors++;
          $display("FAIL bp_hold inst%0d cyc%0d: out_valid=%b in_ready=%b data_out=%h expected 1 0 %h",
                   i, t, out_valid[i], in_ready[i], dout[i], EXP_F1);
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'h0 || in_ready !== 4'hF || busy !== 4'h0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b expected 0000 1111 0000",
               out_valid, in_ready, busy);
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 4'h0 || busy !== 4'h0) begin
        errors++;
        $display("FAIL bp_no_queue cyc%0d: out_valid=%b busy=%b expected 0000 0000", t, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_in   = S_F2;
    inv       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 4'h0 || in_ready !== 4'hF || out_valid !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b in_ready=%b out_valid=%b expected 0000 1111 0000",
               busy, in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 4'h0 || busy !== 4'h0) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc%0d: out_valid=%b busy=%b expected 0000 0000", t, out_valid, busy);
      end
    end
  endtask

  task automatic test_mode_latch();
    run_op(S_F2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== EXP_F2) begin
        errors++;
        $display("FAIL mode_latch_fwd inst%0d: got %h expected %h", i, res[i], EXP_F2);
      end
    end
    run_op(EXP_F2, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== S_F2) begin
        errors++;
        $display("FAIL mode_latch_inv inst%0d: got %h expected %h", i, res[i], S_F2);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_lat    = '{5, 3, 2, 4};
    rst        = 1'b1;
    in_valid   = 1'b0;
    inv        = 1'b0;
    data_in    = '0;
    out_ready  = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_mode_latch();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, columns transformed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter PIPE_OUT, default 1; 1 registers data_out, 0 drives it from the working register.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  a new state is offered.
REQ-006 SHALL have port in_ready  output  1  the engine accepts a state this cycle.
REQ-007 SHALL have port inv  input  1  mode, sampled with the input: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port data_in  input  128  state; column c in bits [127-32c -: 32]; byte 0 of a column in bits [31:24].
REQ-009 SHALL have port out_valid  output  1  data_out holds a completed result.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result.
REQ-011 SHALL have port data_out  output  128  transformed state, same layout as data_in.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and HOLD.
REQ-014 In IDLE, in_ready SHALL be 1; when in_valid=1 the engine SHALL latch data_in and inv, clear the column counter and go to CALC.
REQ-015 In CALC, each cycle the engine SHALL replace COLS_PER_CYCLE columns, starting at the column index in the counter, with their transform; the counter SHALL then advance by COLS_PER_CYCLE.
REQ-016 CALC SHALL last exactly N = 4/COLS_PER_CYCLE cycles; after the last column it SHALL go to HOLD.
REQ-017 out_valid SHALL assert N+PIPE_OUT cycles after the acceptance edge.
REQ-018 In HOLD, out_valid SHALL be 1 and data_out SHALL stay stable until out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-019 in_ready SHALL be 0 in CALC and HOLD; in_valid SHALL be ignored there, with no queuing.
REQ-020 Forward column math SHALL be: b0 = 2a0^3a1^a2^a3, with each following output byte using the same coefficients rotated right by one position.
REQ-021 Inverse column math SHALL use the coefficient row {0e, 0b, 0d, 09}, rotated right by one position for each following output byte.
REQ-022 All multiplies SHALL be in GF(2^8) mod x^8+x^4+x^3+x+1, built from xtime chains with no lookup tables.
REQ-023 The byte width SHALL stay 8 bits throughout, with no carry out.
REQ-024 The mode SHALL be fixed for the whole operation; a change on inv after acceptance SHALL have no effect.
REQ-025 If out_ready is already 1 when out_valid rises, the handshake SHALL complete that cycle, and in_ready SHALL be 1 on the next cycle.
REQ-026 An illegal COLS_PER_CYCLE SHALL stop elaboration.

Reset
REQ-027 When rst=1, the FSM SHALL go to IDLE and the counter SHALL clear on the next edge.
REQ-028 Reset values SHALL be: out_valid=0, busy=0, in_ready=1 (after the reset edge), data_out=0.
REQ-029 Reset in CALC or HOLD SHALL discard the operation in progress, with no output emitted.
REQ-030 rst SHALL take priority over any handshake in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the reduction polynomial constant 8'h1B and the xtime/gmul functions.
REQ-032 The column transform SHALL be the sub-module mix_column_unit (32-bit in, 32-bit out, inv input, purely combinational), instantiated COLS_PER_CYCLE times.

Verification
REQ-033 Forward vectors SHALL be checked: column db135345 -> 8e4da1bc, column f20a225c -> 9fdc589d, column c6c6c6c6 -> c6c6c6c6.
REQ-034 Inverse vectors SHALL be checked: 8e4da1bc -> db135345, and for random states InvMix(Mix(s)) = s, over 1000 vectors per COLS_PER_CYCLE value.
REQ-035 Latency SHALL be checked with out_ready tied to 1: out_valid rises at cycle 5/3/2 after acceptance for COLS_PER_CYCLE 1/2/4 with PIPE_OUT=1.
REQ-036 Backpressure SHALL be checked: hold out_ready=0 for 10 cycles -> data_out stable, in_ready=0 and a new in_valid ignored; on release -> one output, then IDLE.
REQ-037 Reset mid-operation SHALL be checked: assert rst in the 2nd CALC cycle -> out_valid never asserts, busy=0 and in_ready=1 on the cycle after the reset edge.
REQ-038 Mode latching SHALL be checked: toggle inv during CALC -> the result matches the mode sampled at acceptance.
